// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace checker: record kinds, checker
// states and the layout of one captured commit-event bundle.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } traceKind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } checkState_t;

    // One cycle's worth of commit events; regWr sits at bit 0, halt at the top.
    typedef struct packed {
        logic        halt;
        logic [15:0] memWdata;
        logic [15:0] memRdata;
        logic [15:0] memAddr;
        logic        memWr;
        logic        memRd;
        logic [15:0] regData;
        logic [3:0]  regNum;
        logic        regWr;
    } evBundle_t;

    localparam int BUNDLE_W = $bits(evBundle_t);

    localparam int OFF_REG_WR    = 0;
    localparam int OFF_REG_NUM   = 1;
    localparam int OFF_REG_DATA  = 5;
    localparam int OFF_MEM_RD    = 21;
    localparam int OFF_MEM_WR    = 22;
    localparam int OFF_MEM_ADDR  = 23;
    localparam int OFF_MEM_RDATA = 39;
    localparam int OFF_MEM_WDATA = 55;
    localparam int OFF_HALT      = 71;

    // Slots present in a bundle, one bit per kind, indexed by traceKind_t.
    function automatic logic [3:0] slotMask(input evBundle_t b);
        return {b.halt, b.memWr, b.memRd, b.regWr};
    endfunction

endpackage

// File: rtl/trace_evt_fifo.sv
// Synchronous FIFO holding captured event bundles until the checker
// compares them. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module trace_evt_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             wrEn;
    logic             rdEn;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wrEn    = push && (!full || pop);
    assign rdEn    = pop && !empty;
    assign popData = mem[rdPtr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares the CPU's live commit events, in order, against a golden record
// stream and reports pass/fail, mismatch count, first failing record index
// and committed-instruction count.
module commit_trace_checker
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_reg_wr,
    input  logic [3:0]       ev_reg_num,
    input  logic [15:0]      ev_reg_data,
    input  logic             ev_mem_rd,
    input  logic             ev_mem_wr,
    input  logic [15:0]      ev_mem_addr,
    input  logic [15:0]      ev_mem_rdata,
    input  logic [15:0]      ev_mem_wdata,
    input  logic             ev_halt,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [1:0]       exp_kind,
    input  logic [3:0]       exp_reg,
    input  logic [15:0]      exp_addr,
    input  logic [15:0]      exp_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             overflow,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FAW:0]     FIFO_ONE = {{FAW{1'b0}}, 1'b1};

    checkState_t          state;
    logic [3:0]           doneMask;
    logic [CNT_W-1:0]     recIdx;

    evBundle_t            capBundle;
    evBundle_t            head;
    logic [BUNDLE_W-1:0]  fifoRdData;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [FAW:0]         fifoCount;

    logic                 evAny;
    logic                 capture;
    logic                 countsInst;
    logic                 consume;
    logic                 popFifo;
    logic                 overflowNow;
    logic                 moreQueued;
    logic [3:0]           pending;
    logic [3:0]           curBit;
    traceKind_t           curKind;
    logic                 lastSlot;
    logic                 fieldOk;
    logic                 recMismatch;

    assign evAny      = ev_reg_wr | ev_mem_rd | ev_mem_wr | ev_halt;
    assign capture    = evAny && ((state == ST_IDLE) || (state == ST_CHECK));
    assign countsInst = ev_reg_wr | ev_mem_wr | ev_halt;

    assign capBundle = '{halt:     ev_halt,
                         memWdata: ev_mem_wdata,
                         memRdata: ev_mem_rdata,
                         memAddr:  ev_mem_addr,
                         memWr:    ev_mem_wr,
                         memRd:    ev_mem_rd,
                         regData:  ev_reg_data,
                         regNum:   ev_reg_num,
                         regWr:    ev_reg_wr};

    trace_evt_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (FIFO_DEPTH)
    ) evtFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (capture),
        .pushData (capBundle),
        .pop      (popFifo),
        .popData  (fifoRdData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign head     = evBundle_t'(fifoRdData);
    assign pending  = slotMask(head) & ~doneMask;
    assign curBit   = 4'b0001 << curKind;
    assign lastSlot = ((pending & ~curBit) == 4'b0000);

    // Current slot is the first still-unchecked event in REG, LOAD, STORE, HALT order.
    always_comb begin
        curKind = KIND_HALT;
        if (pending[0]) begin
            curKind = KIND_REG;
        end else if (pending[1]) begin
            curKind = KIND_LOAD;
        end else if (pending[2]) begin
            curKind = KIND_STORE;
        end
    end

    // Compare the presented golden record against the current slot's fields.
    always_comb begin
        fieldOk = 1'b0;
        case (curKind)
            KIND_REG:   fieldOk = (exp_reg == head.regNum) && (exp_data == head.regData);
            KIND_LOAD:  fieldOk = (exp_addr == head.memAddr) && (exp_data == head.memRdata);
            KIND_STORE: fieldOk = (exp_addr == head.memAddr) && (exp_data == head.memWdata);
            KIND_HALT:  fieldOk = 1'b1;
            default:    fieldOk = 1'b0;
        endcase
        recMismatch = (exp_kind != curKind) || !fieldOk;
    end

    assign consume     = (state == ST_CHECK) && exp_valid;
    assign exp_ready   = consume;
    assign popFifo     = consume && lastSlot;
    assign overflowNow = capture && fifoFull && !popFifo;
    assign moreQueued  = (fifoCount > FIFO_ONE) || capture;
    assign pass        = done & ~fail;

    // Checker FSM, counters and sticky status; an overflow overrides any compare outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            doneMask       <= '0;
            recIdx         <= '0;
            done           <= 1'b0;
            fail           <= 1'b0;
            overflow       <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            inst_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        state    <= ST_CHECK;
                        doneMask <= '0;
                    end
                end
                ST_CHECK: begin
                    if (consume) begin
                        recIdx <= recIdx + CNT_ONE;
                        if (recMismatch) begin
                            fail <= 1'b1;
                            if (mismatch_cnt != '1) begin
                                mismatch_cnt <= mismatch_cnt + CNT_ONE;
                            end
                            if (!fail) begin
                                first_fail_idx <= recIdx;
                            end
                        end
                        if (recMismatch && STOP_ON_FAIL) begin
                            state <= ST_FAIL;
                            done  <= 1'b1;
                        end else if (curKind == KIND_HALT) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (lastSlot) begin
                            doneMask <= '0;
                            state    <= moreQueued ? ST_CHECK : ST_IDLE;
                        end else begin
                            doneMask <= doneMask | curBit;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase

            if (capture) begin
                if (countsInst) begin
                    inst_cnt <= inst_cnt + CNT_ONE;
                end
                if (overflowNow) begin
                    overflow <= 1'b1;
                    fail     <= 1'b1;
                    done     <= 1'b1;
                    state    <= ST_FAIL;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Scoreboard bench for commit_trace_checker: each scenario queues its golden
// records and the expected final status; a monitor compares the status when
// done rises.
module tb_commit_trace_checker;

    localparam logic [1:0] KREG   = 2'd0;
    localparam logic [1:0] KLOAD  = 2'd1;
    localparam logic [1:0] KSTORE = 2'd2;
    localparam logic [1:0] KHALT  = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  rnum;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        ovf;
        logic [15:0] mm;
        logic [15:0] ffi;
        logic [15:0] inst;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_reg_wr, ev_mem_rd, ev_mem_wr, ev_halt;
    logic [3:0]  ev_reg_num;
    logic [15:0] ev_reg_data, ev_mem_addr, ev_mem_rdata, ev_mem_wdata;
    logic        exp_valid, exp_ready;
    logic [1:0]  exp_kind;
    logic [3:0]  exp_reg;
    logic [15:0] exp_addr, exp_data;
    logic        done, pass, fail, overflow;
    logic [15:0] mismatch_cnt, first_fail_idx, inst_cnt;

    rec_t recQ[$];
    res_t expQ[$];
    res_t curExp;
    bit   recEnable = 1'b0;
    bit   doneSeen  = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    commit_trace_checker #(
        .FIFO_DEPTH   (8),
        .CNT_W        (16),
        .STOP_ON_FAIL (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ev_reg_wr      (ev_reg_wr),
        .ev_reg_num     (ev_reg_num),
        .ev_reg_data    (ev_reg_data),
        .ev_mem_rd      (ev_mem_rd),
        .ev_mem_wr      (ev_mem_wr),
        .ev_mem_addr    (ev_mem_addr),
        .ev_mem_rdata   (ev_mem_rdata),
        .ev_mem_wdata   (ev_mem_wdata),
        .ev_halt        (ev_halt),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_kind       (exp_kind),
        .exp_reg        (exp_reg),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .overflow       (overflow),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .inst_cnt       (inst_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic regWr, input logic [3:0] num, input logic [15:0] rdata16,
                                 input logic memRd, input logic memWr, input logic [15:0] addr,
                                 input logic [15:0] memRdata, input logic [15:0] memWdata, input logic halt);
        @(negedge clk);
        ev_reg_wr    = regWr;
        ev_reg_num   = num;
        ev_reg_data  = rdata16;
        ev_mem_rd    = memRd;
        ev_mem_wr    = memWr;
        ev_mem_addr  = addr;
        ev_mem_rdata = memRdata;
        ev_mem_wdata = memWdata;
        ev_halt      = halt;
        @(posedge clk);
        #1;
        ev_reg_wr = 1'b0; ev_mem_rd = 1'b0; ev_mem_wr = 1'b0; ev_halt = 1'b0;
        ev_reg_num = '0; ev_reg_data = '0; ev_mem_addr = '0; ev_mem_rdata = '0; ev_mem_wdata = '0;
    endtask

    task automatic pushRecord(input logic [1:0] kind, input logic [3:0] rnum, input logic [15:0] addr, input logic [15:0] data);
        rec_t r;
        r.kind = kind; r.rnum = rnum; r.addr = addr; r.data = data;
        recQ.push_back(r);
    endtask

    task automatic expectResult(input logic p, input logic f, input logic o, input logic [15:0] mm,
                                input logic [15:0] ffi, input logic [15:0] inst);
        res_t e;
        e.pass = p; e.fail = f; e.ovf = o; e.mm = mm; e.ffi = ffi; e.inst = inst;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        recEnable = 1'b0;
        recQ.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        #1;
        checkOutput({tag, "Done"},     {15'd0, done},     16'd0);
        checkOutput({tag, "Pass"},     {15'd0, pass},     16'd0);
        checkOutput({tag, "Fail"},     {15'd0, fail},     16'd0);
        checkOutput({tag, "Overflow"}, {15'd0, overflow}, 16'd0);
        checkOutput({tag, "ExpReady"}, {15'd0, exp_ready}, 16'd0);
        checkOutput({tag, "Mismatch"}, mismatch_cnt,      16'd0);
        checkOutput({tag, "FirstIdx"}, first_fail_idx,    16'd0);
        checkOutput({tag, "InstCnt"},  inst_cnt,          16'd0);
    endtask

    task automatic waitDone(input string tag, input int limit, input bit checkRecs);
        int n = 0;
        while (expQ.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: done not seen within %0d cycles", tag, limit);
            expQ.delete();
        end
        if (checkRecs) begin
            checkOutput({tag, "RecsLeft"}, 16'(recQ.size()), 16'd0);
        end
    endtask

    // Golden record source: presents the queue head and drops it once accepted.
    initial begin
        exp_valid = 1'b0; exp_kind = '0; exp_reg = '0; exp_addr = '0; exp_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (recEnable && recQ.size() > 0) begin
                exp_valid = 1'b1;
                exp_kind  = recQ[0].kind;
                exp_reg   = recQ[0].rnum;
                exp_addr  = recQ[0].addr;
                exp_data  = recQ[0].data;
            end else begin
                exp_valid = 1'b0;
            end
            #1;
            if (exp_valid && exp_ready) begin
                recQ.delete(0);
            end
        end
    end

    // Monitor: on each rising done, pop the expected status and compare.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (done && !doneSeen) begin
                doneSeen = 1'b1;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone: done=1 with no expected result queued");
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("pass",     {15'd0, pass},      {15'd0, curExp.pass});
                    checkOutput("fail",     {15'd0, fail},      {15'd0, curExp.fail});
                    checkOutput("overflow", {15'd0, overflow},  {15'd0, curExp.ovf});
                    checkOutput("expReady", {15'd0, exp_ready}, 16'd0);
                    checkOutput("mismatch", mismatch_cnt,       curExp.mm);
                    checkOutput("firstIdx", first_fail_idx,     curExp.ffi);
                    checkOutput("instCnt",  inst_cnt,           curExp.inst);
                end
            end else if (!done) begin
                doneSeen = 1'b0;
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        rst = 1'b0;
        ev_reg_wr = 1'b0; ev_mem_rd = 1'b0; ev_mem_wr = 1'b0; ev_halt = 1'b0;
        ev_reg_num = '0; ev_reg_data = '0; ev_mem_addr = '0; ev_mem_rdata = '0; ev_mem_wdata = '0;

        doReset();
        checkReset("rst0");

        $display("[TB] scenario: REG then HALT");
        doReset();
        pushRecord(KREG, 4'd3, 16'h0000, 16'h1234);
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd2);
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("regHalt", 100, 1'b1);

        $display("[TB] scenario: REG+LOAD same cycle, in order");
        doReset();
        pushRecord(KREG, 4'd1, 16'h0000, 16'h0005);
        pushRecord(KLOAD, 4'd0, 16'h0010, 16'hBEEF);
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd2);
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd1, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("regLoad", 100, 1'b1);

        $display("[TB] scenario: REG+LOAD same cycle, records swapped");
        doReset();
        pushRecord(KLOAD, 4'd0, 16'h0010, 16'hBEEF);
        pushRecord(KREG, 4'd1, 16'h0000, 16'h0005);
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd2);
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd1, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("swapped", 100, 1'b1);

        $display("[TB] scenario: STORE data miscompare, continue to HALT");
        doReset();
        pushRecord(KREG, 4'd2, 16'h0000, 16'h0007);
        pushRecord(KSTORE, 4'd0, 16'h0020, 16'h00AB);
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b0, 1'b1, 1'b0, 16'd1, 16'd1, 16'd3);
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd2, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h00AA, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("storeBad", 100, 1'b1);

        $display("[TB] scenario: 9 events with no records, FIFO overflows");
        doReset();
        expectResult(1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 16'd9);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 4'(i), 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        waitDone("overflow", 20, 1'b0);

        $display("[TB] scenario: FIFO full with push and pop in the same cycle");
        doReset();
        for (int i = 0; i < 9; i++) begin
            pushRecord(KREG, 4'(i + 1), 16'h0000, 16'h0200 + 16'(i));
        end
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd10);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 16'h0200 + 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd9, 16'h0208, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("fullPushPop", 100, 1'b1);

        $display("[TB] scenario: reset mid-check with bundles queued");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i + 4), 16'h0300 + 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        repeat (2) @(negedge clk);
        doReset();
        checkReset("rstMid");
        pushRecord(KREG, 4'd5, 16'h0000, 16'h0055);
        pushRecord(KHALT, 4'd0, 16'h0000, 16'h0000);
        expectResult(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd2);
        recEnable = 1'b1;
        applyStimulus(1'b1, 4'd5, 16'h0055, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDone("afterRst", 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
